// File: rtl/mc6809_dma_arbiter_if.sv
// Bus bundle between the MC6809 DMA arbiter and its surroundings: core-side
// BA/BS/nDMABREQ plus the per-master request/done/grant lines.
interface mc6809_dma_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic            BA;
    logic            BS;
    logic            nDMABREQ;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            dma_active;
    logic            forced;
    logic            abort;
    logic [1:0]      dbg_state;

    // Handshake: a master raises req and holds it; it owns the bus for every
    // cycle its gnt bit is 1 and ends the tenure with a one-cycle done pulse
    // or by dropping req. The core grants the bus while BA=1 and BS=1.
    modport master (
        input  req, done, BA, BS,
        output nDMABREQ, gnt, gnt_id, dma_active, forced, abort, dbg_state
    );

    modport slave (
        output req, done, BA, BS,
        input  nDMABREQ, gnt, gnt_id, dma_active, forced, abort, dbg_state
    );
endinterface

// File: rtl/mc6809_dma_arbiter.sv
// Round-robin arbiter sharing the MC6809 bus among NREQ DMA masters through
// nDMABREQ, with tenures capped at MAX_BURST cycles for the core's refresh limit.
module mc6809_dma_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 14,
    parameter int MIN_GAP   = 2
) (
    input logic                  CLK,
    input logic                  nRESET,
    mc6809_dma_arbiter_if.master bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int BW  = $clog2(MAX_BURST + 1);
    localparam int GW  = $clog2(MIN_GAP + 1);

    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0] BURST_SAT  = BW'(MAX_BURST);
    localparam logic [GW-1:0] GAP_LAST   = GW'(MIN_GAP - 1);
    localparam logic [GW-1:0] GAP_SAT    = GW'(MIN_GAP);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [IDW-1:0]  rr_ptr, rr_n;
    logic [BW-1:0]   burst, burst_n;
    logic [GW-1:0]   gap, gap_n;
    logic [NREQ-1:0] gnt_q, gnt_n;
    logic [IDW-1:0]  gnt_id_q, gnt_id_n;
    logic            forced_q, forced_n;
    logic            abort_q, abort_n;
    logic            nbreq_q;

    logic            granted;
    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic            win_done;
    logic            win_req;
    logic [IDW-1:0]  rr_after;

    assign granted  = bus.BA && bus.BS;
    assign win_done = bus.done[gnt_id_q];
    assign win_req  = bus.req[gnt_id_q];
    assign rr_after = (gnt_id_q == ID_LAST) ? '0 : gnt_id_q + 1'b1;

    // First requester at or above the round-robin pointer, wrapping to 0.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!win_found && bus.req[j]) begin
                win_found = 1'b1;
                win_idx   = IDW'(j);
            end
        end
    end

    always_comb begin
        state_n  = state;
        rr_n     = rr_ptr;
        burst_n  = burst;
        gap_n    = gap;
        gnt_n    = gnt_q;
        gnt_id_n = gnt_id_q;
        forced_n = 1'b0;
        abort_n  = 1'b0;
        case (state)
            IDLE: begin
                gap_n = '0;
                if (|bus.req) state_n = REQ;
            end
            REQ: begin
                if (bus.req == '0) begin
                    state_n = RELEASE;
                    gap_n   = '0;
                end else if (granted && win_found) begin
                    gnt_n          = '0;
                    gnt_n[win_idx] = 1'b1;
                    gnt_id_n       = win_idx;
                    burst_n        = '0;
                    state_n        = GRANT;
                end
            end
            GRANT: begin
                burst_n = (burst == BURST_SAT) ? burst : burst + 1'b1;
                // Exit priority: lost bus, then normal end, then burst cap.
                if (!granted || win_done || !win_req || burst == BURST_LAST) begin
                    state_n = RELEASE;
                    gnt_n   = '0;
                    rr_n    = rr_after;
                    gap_n   = '0;
                    if (!granted) abort_n = 1'b1;
                    else if (!(win_done || !win_req)) forced_n = 1'b1;
                end
            end
            RELEASE: begin
                if (gap >= GAP_LAST && !bus.BA) begin
                    state_n = IDLE;
                    gap_n   = '0;
                end else begin
                    gap_n = (gap == GAP_SAT) ? gap : gap + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            burst    <= '0;
            gap      <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            forced_q <= 1'b0;
            abort_q  <= 1'b0;
            nbreq_q  <= 1'b1;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_n;
            burst    <= burst_n;
            gap      <= gap_n;
            gnt_q    <= gnt_n;
            gnt_id_q <= gnt_id_n;
            forced_q <= forced_n;
            abort_q  <= abort_n;
            nbreq_q  <= !(state_n == REQ || state_n == GRANT);
        end
    end

    assign bus.nDMABREQ   = nbreq_q;
    assign bus.gnt        = gnt_q;
    assign bus.gnt_id     = gnt_id_q;
    assign bus.dma_active = |gnt_q;
    assign bus.forced     = forced_q;
    assign bus.abort      = abort_q;
    assign bus.dbg_state  = state;
endmodule
